// File: rtl/alu_serial_rx.sv
// Command deserializer for the ALU serial link: rebuilds A, B and op from
// 11-bit frames and issues one command or one error pulse per packet.
module alu_serial_rx #(
    parameter int DATA_BYTES   = 8,
    parameter bit CRC_CHECK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        cmd_valid,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_BYTE_DONE,
        S_GAP,
        S_CHECK,
        S_REPORT
    } state_t;

    localparam logic [3:0] BYTES_REQ = 4'(DATA_BYTES);

    // CRC-4, x^4+x+1, init 0, MSB first, no reflection, no final XOR.
    function automatic logic [3:0] crc4_msb(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [63:0] store_q, store_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ctl_q, ctl_d;
    logic        stop_q, stop_d;
    logic [2:0]  op_rx_q, op_rx_d;
    logic [3:0]  crc_rx_q, crc_rx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_data_q, err_data_d;
    logic        err_crc_q, err_crc_d;
    logic        err_op_q, err_op_d;
    logic [3:0]  crc_calc;

    assign crc_calc = crc4_msb({store_q, 1'b1, op_rx_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!sin) state_d = S_RX;
            end
            S_RX: begin
                if (bit_cnt_q == 4'd10) state_d = S_BYTE_DONE;
            end
            S_BYTE_DONE: begin
                if (!stop_q) begin
                    state_d = S_REPORT;
                end else if (!ctl_q) begin
                    // A start bit may follow the stop bit with no idle gap.
                    state_d = sin ? S_GAP : S_RX;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_GAP: begin
                if (!sin) state_d = S_RX;
            end
            S_CHECK:  state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= 4'd0;
            byte_cnt_q  <= 4'd0;
            store_q     <= 64'd0;
            shreg_q     <= 8'd0;
            ctl_q       <= 1'b0;
            stop_q      <= 1'b0;
            op_rx_q     <= 3'd0;
            crc_rx_q    <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 3'd0;
            cmd_valid_q <= 1'b0;
            err_data_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            store_q     <= store_d;
            shreg_q     <= shreg_d;
            ctl_q       <= ctl_d;
            stop_q      <= stop_d;
            op_rx_q     <= op_rx_d;
            crc_rx_q    <= crc_rx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cmd_valid_q <= cmd_valid_d;
            err_data_q  <= err_data_d;
            err_crc_q   <= err_crc_d;
            err_op_q    <= err_op_d;
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        store_d     = store_q;
        shreg_d     = shreg_q;
        ctl_d       = ctl_q;
        stop_d      = stop_q;
        op_rx_d     = op_rx_q;
        crc_rx_d    = crc_rx_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cmd_valid_d = 1'b0;
        err_data_d  = 1'b0;
        err_crc_d   = 1'b0;
        err_op_d    = 1'b0;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (!sin) bit_cnt_d = 4'd1;
            end
            S_RX: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd1) begin
                    ctl_d = sin;
                end else if (bit_cnt_q == 4'd10) begin
                    stop_d = sin;
                end else begin
                    shreg_d = {shreg_q[6:0], sin};
                end
            end
            S_BYTE_DONE: begin
                if (!stop_q) begin
                    err_data_d = 1'b1;
                end else if (!ctl_q) begin
                    store_d    = {store_q[55:0], shreg_q};
                    byte_cnt_d = (byte_cnt_q == 4'd15) ? 4'd15 : byte_cnt_q + 4'd1;
                    if (!sin) bit_cnt_d = 4'd1;
                end else begin
                    op_rx_d  = shreg_q[6:4];
                    crc_rx_d = shreg_q[3:0];
                end
            end
            S_CHECK: begin
                // Exactly one result flag, in priority order.
                if (byte_cnt_q != BYTES_REQ) begin
                    err_data_d = 1'b1;
                end else if (CRC_CHECK_EN && (crc_calc != crc_rx_q)) begin
                    err_crc_d = 1'b1;
                end else if (!op_legal(op_rx_q)) begin
                    err_op_d = 1'b1;
                end else begin
                    cmd_valid_d = 1'b1;
                    a_d         = store_q[31:0];
                    b_d         = store_q[63:32];
                    op_d        = op_rx_q;
                end
            end
            S_REPORT: begin
                bit_cnt_d  = 4'd0;
                byte_cnt_d = 4'd0;
                store_d    = 64'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        a_out     = a_q;
        b_out     = b_q;
        op_out    = op_q;
        cmd_valid = cmd_valid_q;
        err_data  = err_data_q;
        err_crc   = err_crc_q;
        err_op    = err_op_q;
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: drives framed packets on sin and checks
// result pulses, held operands, latency and reset behaviour.
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] a_out, b_out, a2, b2;
    logic [2:0]  op_out, op2;
    logic        cmd_valid, err_data, err_crc, err_op, busy;
    logic        cv2, ed2, ec2, eo2, busy2;

    always #5 clk = ~clk;

    alu_serial_rx dut (
        .clk(clk), .rst(rst), .sin(sin),
        .a_out(a_out), .b_out(b_out), .op_out(op_out),
        .cmd_valid(cmd_valid), .err_data(err_data), .err_crc(err_crc),
        .err_op(err_op), .busy(busy)
    );

    alu_serial_rx #(.CRC_CHECK_EN(1'b0)) dut_nocrc (
        .clk(clk), .rst(rst), .sin(sin),
        .a_out(a2), .b_out(b2), .op_out(op2),
        .cmd_valid(cv2), .err_data(ed2), .err_crc(ec2),
        .err_op(eo2), .busy(busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, stop_cyc = 0, pulse_cyc = -1;
    int cnt_cv, cnt_ed, cnt_ec, cnt_eo, cnt_multi, cnt_cv2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC by long division of msg*x^4 by 10011.
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic clear_counts();
        cnt_cv = 0; cnt_ed = 0; cnt_ec = 0; cnt_eo = 0; cnt_multi = 0; cnt_cv2 = 0;
        pulse_cyc = -1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        cyc++;
        if (cmd_valid) cnt_cv++;
        if (err_data)  cnt_ed++;
        if (err_crc)   cnt_ec++;
        if (err_op)    cnt_eo++;
        if (cv2)       cnt_cv2++;
        if ($countones({cmd_valid, err_data, err_crc, err_op}) > 1) cnt_multi++;
        if ((cmd_valid | err_data | err_crc | err_op) && pulse_cyc < 0) pulse_cyc = cyc;
        sin = b;
    endtask

    task automatic send_frame(input logic ctl, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(ctl);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
        stop_cyc = cyc;
    endtask

    task automatic send_data(input logic [63:0] v, input int n, input int gap);
        logic [7:0] bt;
        for (int i = 0; i < n; i++) begin
            bt = v[63 - 8 * (i % 8) -: 8];
            send_frame(1'b0, bt, 1'b1);
            repeat (gap) send_bit(1'b1);
        end
    endtask

    task automatic send_ctl(input logic [2:0] op, input logic [3:0] crc, input logic stop);
        send_frame(1'b1, {1'b0, op, crc}, stop);
        repeat (8) send_bit(1'b1);
    endtask

    task automatic expect_flags(input string tag, input int cv, input int ed,
                                input int ec, input int eo);
        check_eq({tag, "_flags"}, {32'(cnt_cv), 8'(cnt_ed), 8'(cnt_ec), 8'(cnt_eo), 8'(cnt_multi)},
                 {32'(cv), 8'(ed), 8'(ec), 8'(eo), 8'd0});
    endtask

    task automatic expect_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op);
        check_eq({tag, "_a"},  64'(a_out),  64'(a));
        check_eq({tag, "_b"},  64'(b_out),  64'(b));
        check_eq({tag, "_op"}, 64'(op_out), 64'(op));
    endtask

    logic [31:0] ta, tb;
    logic [2:0]  top;
    logic [3:0]  tcrc;
    logic [2:0]  bad_ops [4] = '{3'b010, 3'b011, 3'b110, 3'b111};

    initial begin
        sin = 1'b1;
        rst = 1'b1;
        clear_counts();
        repeat (3) send_bit(1'b1);
        check_eq("reset_outputs", {a_out, b_out, 4'(op_out), cmd_valid, err_data, err_crc, err_op, busy},
                 {32'd0, 32'd0, 4'd0, 5'b00000});
        rst = 1'b0;
        repeat (2) send_bit(1'b1);

        // Basic good packet: B=3, A=5, ADD.
        clear_counts();
        ta = 32'h5; tb = 32'h3; top = 3'b100;
        tcrc = crc_ref(tb, ta, top);
        send_data({tb, ta}, 8, 2);
        send_ctl(top, tcrc, 1'b1);
        expect_flags("good_add", 1, 0, 0, 0);
        check_eq("good_add_latency", 64'(pulse_cyc - stop_cyc), 64'd3);
        expect_cmd("good_add", ta, tb, top);
        check_eq("good_add_busy", 64'(busy), 64'd0);

        // Corrupted CRC: error here, accepted when CRC checking is off.
        clear_counts();
        send_data({32'h0000_0003, 32'h0000_0005}, 8, 1);
        send_ctl(3'b100, tcrc ^ 4'h1, 1'b1);
        expect_flags("bad_crc", 0, 0, 1, 0);
        expect_cmd("bad_crc_hold", 32'h5, 32'h3, 3'b100);
        check_eq("bad_crc_nocheck_cv", 64'(cnt_cv2), 64'd1);

        // Byte count errors: 7, 9 and zero data bytes.
        clear_counts();
        send_data({tb, ta}, 7, 1);
        send_ctl(top, tcrc, 1'b1);
        expect_flags("seven_bytes", 0, 1, 0, 0);
        check_eq("seven_bytes_latency", 64'(pulse_cyc - stop_cyc), 64'd3);
        clear_counts();
        send_data({tb, ta}, 9, 1);
        send_ctl(top, tcrc, 1'b1);
        expect_flags("nine_bytes", 0, 1, 0, 0);
        clear_counts();
        send_ctl(top, tcrc, 1'b1);
        expect_flags("zero_bytes", 0, 1, 0, 0);
        expect_cmd("count_err_hold", 32'h5, 32'h3, 3'b100);

        clear_counts();
        ta = 32'h9ABC_DEF0; tb = 32'h1234_5678; top = 3'b000;
        send_data({tb, ta}, 8, 1);
        send_ctl(top, crc_ref(tb, ta, top), 1'b1);
        expect_flags("good_and", 1, 0, 0, 0);
        expect_cmd("good_and", ta, tb, top);

        // Illegal opcodes with a matching CRC.
        for (int k = 0; k < 4; k++) begin
            clear_counts();
            send_data({32'h0000_00AA, 32'h0000_0055}, 8, 1);
            send_ctl(bad_ops[k], crc_ref(32'hAA, 32'h55, bad_ops[k]), 1'b1);
            expect_flags($sformatf("bad_op%0d", k), 0, 0, 0, 1);
        end
        expect_cmd("bad_op_hold", ta, tb, top);

        // Framing error on the control byte.
        clear_counts();
        send_data({tb, ta}, 8, 1);
        send_ctl(3'b001, crc_ref(tb, ta, 3'b001), 1'b0);
        expect_flags("frame_err", 0, 1, 0, 0);
        check_eq("frame_err_latency", 64'(pulse_cyc - stop_cyc), 64'd2);
        check_eq("frame_err_busy", 64'(busy), 64'd0);
        clear_counts();
        ta = 32'h0F0F_0F0F; tb = 32'hF0F0_F0F0; top = 3'b001;
        send_data({tb, ta}, 8, 3);
        send_ctl(top, crc_ref(tb, ta, top), 1'b1);
        expect_flags("after_frame_err", 1, 0, 0, 0);
        expect_cmd("good_or", ta, tb, top);

        // Reset in the middle of byte 4.
        clear_counts();
        send_data({32'h1111_2222, 32'h3333_4444}, 3, 1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_outputs", {a_out, b_out, 4'(op_out), cmd_valid, err_data, err_crc, err_op, busy},
                 {32'd0, 32'd0, 4'd0, 5'b00000});
        repeat (2) send_bit(1'b1);
        rst = 1'b0;
        send_bit(1'b1);

        // Full good packet with back-to-back bytes.
        clear_counts();
        ta = 32'hFFFF_FFFF; tb = 32'h0000_0001; top = 3'b101;
        send_data({tb, ta}, 8, 0);
        send_ctl(top, crc_ref(tb, ta, top), 1'b1);
        expect_flags("after_rst_sub", 1, 0, 0, 0);
        expect_cmd("after_rst_sub", ta, tb, top);
        check_eq("after_rst_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
